// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters (req0 = execute unit,
//   req1 = address/PC unit). A round-robin arbiter picks one requester, its
//   operands are registered onto the ALU inputs and held for EXEC_CYCLES
//   cycles, then the ALU result and flags are captured and returned on a shared
//   response bus. Only one operation is in flight at any time.
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o        N=0,1 request handshake (ready is
//                                      combinational, only in IDLE)
//   reqN_x_i, reqN_y_i                 N=0,1 operands
//   reqN_functionals_i, reqN_logicfn_i N=0,1 ALU function / logic sub-function
//   respN_valid_o / respN_ready_i      N=0,1 response handshake
//   resp_value_o, resp_carry_o, resp_zeroflag_o, resp_msb_o, resp_overflow_o
//                                      captured ALU result and flags
//   alu_x_o, alu_y_o, alu_functionals_o, alu_logicfn_o
//                                      registered operands driven to the ALU
//   alu_value_i, alu_carry_i, alu_zeroflag_i, alu_msb_i, alu_overflow_i
//                                      ALU result and flags
//   busy_o                             high while an operation is in EXEC/RESP
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1   // 1..15
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_x_i,
  input  logic [WIDTH-1:0] req0_y_i,
  input  logic [1:0]       req0_functionals_i,
  input  logic [2:0]       req0_logicfn_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_x_i,
  input  logic [WIDTH-1:0] req1_y_i,
  input  logic [1:0]       req1_functionals_i,
  input  logic [2:0]       req1_logicfn_i,

  output logic             resp0_valid_o,
  input  logic             resp0_ready_i,
  output logic             resp1_valid_o,
  input  logic             resp1_ready_i,
  output logic [WIDTH-1:0] resp_value_o,
  output logic             resp_carry_o,
  output logic             resp_zeroflag_o,
  output logic             resp_msb_o,
  output logic             resp_overflow_o,

  output logic [WIDTH-1:0] alu_x_o,
  output logic [WIDTH-1:0] alu_y_o,
  output logic [1:0]       alu_functionals_o,
  output logic [2:0]       alu_logicfn_o,
  input  logic [WIDTH-1:0] alu_value_i,
  input  logic             alu_carry_i,
  input  logic             alu_zeroflag_i,
  input  logic             alu_msb_i,
  input  logic             alu_overflow_i,

  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_e           state_q;
  logic             last_grant_q;  // requester granted most recently
  logic             owner_q;       // requester of the operation in flight
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             resp0_valid_q;
  logic             resp1_valid_q;

  logic [WIDTH-1:0] alu_x_q;
  logic [WIDTH-1:0] alu_y_q;
  logic [1:0]       alu_functionals_q;
  logic [2:0]       alu_logicfn_q;

  logic [WIDTH-1:0] resp_value_q;
  logic             resp_carry_q;
  logic             resp_zeroflag_q;
  logic             resp_msb_q;
  logic             resp_overflow_q;

  logic             grant0;
  logic             grant1;
  logic             owner_ack;

  // Round-robin winner. On a tie the requester that was not granted last wins;
  // last_grant resets to 1 so req0 wins the first tie.
  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE && !rst_i) begin
      if (req0_valid_i && req1_valid_i) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i;
      end
    end
  end

  // Only the owner's ready releases the response; the other one is ignored.
  assign owner_ack = owner_q ? resp1_ready_i : resp0_ready_i;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Datapath registers are reset too: the ALU operands and the response
      // bus must read zero after reset.
      state_q           <= ST_IDLE;
      last_grant_q      <= 1'b1;
      owner_q           <= 1'b0;
      cnt_q             <= '0;
      busy_q            <= 1'b0;
      resp0_valid_q     <= 1'b0;
      resp1_valid_q     <= 1'b0;
      alu_x_q           <= '0;
      alu_y_q           <= '0;
      alu_functionals_q <= '0;
      alu_logicfn_q     <= '0;
      resp_value_q      <= '0;
      resp_carry_q      <= 1'b0;
      resp_zeroflag_q   <= 1'b0;
      resp_msb_q        <= 1'b0;
      resp_overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            owner_q           <= grant1;
            last_grant_q      <= grant1;
            alu_x_q           <= grant1 ? req1_x_i           : req0_x_i;
            alu_y_q           <= grant1 ? req1_y_i           : req0_y_i;
            alu_functionals_q <= grant1 ? req1_functionals_i : req0_functionals_i;
            alu_logicfn_q     <= grant1 ? req1_logicfn_i     : req0_logicfn_i;
            cnt_q             <= CNT_INIT;
            busy_q            <= 1'b1;
            state_q           <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            resp_value_q    <= alu_value_i;
            resp_carry_q    <= alu_carry_i;
            resp_zeroflag_q <= alu_zeroflag_i;
            resp_msb_q      <= alu_msb_i;
            resp_overflow_q <= alu_overflow_i;
            resp0_valid_q   <= !owner_q;
            resp1_valid_q   <= owner_q;
            state_q         <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_RESP: begin
          // Returning to IDLE takes a full cycle, so no grant happens in the
          // same cycle the response is consumed.
          if (owner_ack) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready_o      = grant0;
  assign req1_ready_o      = grant1;
  assign resp0_valid_o     = resp0_valid_q;
  assign resp1_valid_o     = resp1_valid_q;
  assign resp_value_o      = resp_value_q;
  assign resp_carry_o      = resp_carry_q;
  assign resp_zeroflag_o   = resp_zeroflag_q;
  assign resp_msb_o        = resp_msb_q;
  assign resp_overflow_o   = resp_overflow_q;
  assign alu_x_o           = alu_x_q;
  assign alu_y_o           = alu_y_q;
  assign alu_functionals_o = alu_functionals_q;
  assign alu_logicfn_o     = alu_logicfn_q;
  assign busy_o            = busy_q;

endmodule
